muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised multi-cycle RV32M/RV64M multiply/divide execution unit for the pipelined core, instantiated beside the combinational ALU in the execute stage.
- Radix is configurable: STEPS_PER_CYCLE iteration steps per clock.
- START/BUSY/DONE handshake; BUSY feeds the pipeline stall logic alongside the cache busy-waits.
- FLUSH input aborts an in-flight operation on branch flush.

Parameters:
- XLEN, 32, operand/result width; 32 or 64.
- STEPS_PER_CYCLE, 1, shift-subtract or shift-add steps per clock; must divide XLEN (1, 2, 4).

Ports:
- CLK  input  1  clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- START  input  1  request; sampled only in IDLE.
- FUNCT3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OPERAND_A  input  XLEN  rs1 (multiplicand/dividend).
- OPERAND_B  input  XLEN  rs2 (multiplier/divisor).
- FLUSH  input  1  abort current operation.
- BUSY  output  1  high while in CALC; pipeline stalls on it.
- DONE  output  1  one-cycle pulse; RESULT valid.
- RESULT  output  XLEN  result, held until the next DONE.

Behaviour:
- Reset (async, RESET_N=0): state IDLE; BUSY=0; DONE=0; RESULT=0; internal registers cleared. Reset mid-operation discards the operation and produces no DONE.
- FSM states: IDLE, CALC, FINISH. BUSY=1 only in CALC; DONE=1 only in FINISH.
- IDLE: START=1 and FLUSH=0 latches operands and FUNCT3.
  - Special case (see below) -> FINISH next cycle.
  - Otherwise -> CALC.
- CALC: runs N=XLEN/STEPS_PER_CYCLE cycles, counted by a down-counter; on the last step -> FINISH. DONE rises exactly N+1 cycles after the START edge.
- FINISH: RESULT updated on entry; DONE=1 for one cycle; -> IDLE unconditionally. A START present during FINISH is ignored; the next request is accepted in IDLE.
- START while BUSY: ignored; latched operands unaffected.
- FLUSH=1 in CALC or FINISH: -> IDLE at next edge; DONE suppressed; RESULT unchanged.
- FLUSH together with START in IDLE: FLUSH wins; no operation starts.
- Multiply:
  - Operands converted to magnitudes (signed per FUNCT3: MULH both signed, MULHSU A signed/B unsigned, MULHU/MUL unsigned magnitudes).
  - Iterative shift-add into a 2*XLEN accumulator; product negated at the end if signs differ.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide:
  - Restoring shift-subtract on magnitudes.
  - Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
  - Signed for DIV/REM; unsigned for DIVU/REMU.
- Special cases (no CALC, DONE on the cycle after START):
  - B=0: DIV/DIVU -> all ones; REM/REMU -> A.
  - DIV with A=-2^(XLEN-1) and B=-1 -> A; REM for the same operands -> 0.
- All arithmetic is modulo 2^XLEN; no exceptions raised.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: the four multiply ops use a single-cycle combinational 2*XLEN multiplier. IDLE -> FINISH directly; DONE the cycle after START; BUSY never asserted for multiplies.
- Undefined: multiplies use the iterative path with N-cycle latency. Divide is always iterative.

Test Plan (XLEN=32, STEPS_PER_CYCLE=1, macro undefined unless stated):
- DIV 20 by -3 (0xFFFFFFFD) -> RESULT 0xFFFFFFFA, DONE at cycle 33 after START, BUSY high cycles 1-32. REM with the same operands -> 2.
- DIVU 0x12345678 by 0 -> 0xFFFFFFFF with DONE at cycle 1. REMU with the same operands -> 0x12345678. DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000; REM -> 0.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MUL 7 x -3 -> 0xFFFFFFEB.
- With MULDIV_FAST_MUL_EN defined: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE, DONE at cycle 1, BUSY stays 0.
- Start DIV, assert FLUSH at cycle 10 -> BUSY low at cycle 11, no DONE, RESULT unchanged. Assert a START at cycle 5 of a DIV -> ignored, original result delivered.
- Drop RESET_N mid-CALC -> BUSY/DONE/RESULT immediately 0. After release, DIVU 100 by 7 -> 14 at cycle 33.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M/RV64M multiply/divide unit with START/BUSY/DONE handshake and FLUSH abort.
// Optional macro MULDIV_FAST_MUL_EN: multiplies complete through a single-cycle combinational multiplier.
module muldiv_unit #(
  parameter int XLEN            = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] OPERAND_A,
  input  logic [XLEN-1:0] OPERAND_B,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int N  = XLEN / STEPS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_N   = CW'(N);
  localparam logic [CW-1:0]   CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  logic [1:0]          state_r;
  logic                busy_r;
  logic                done_r;
  logic [XLEN-1:0]     result_r;
  logic [2:0]          funct3_r;
  logic [XLEN-1:0]     opnd_r;
  logic [2*XLEN-1:0]   acc_r;
  logic                neg_q_r;
  logic                neg_rem_r;
  logic [CW-1:0]       cnt_r;

  logic                a_signed_s;
  logic                b_signed_s;
  logic                a_neg_s;
  logic                b_neg_s;
  logic [XLEN-1:0]     mag_a_s;
  logic [XLEN-1:0]     mag_b_s;
  logic                div_zero_s;
  logic                div_ovf_s;
  logic                special_s;
  logic [XLEN-1:0]     special_res_s;
  logic [XLEN-1:0]     load_opnd_s;
  logic [2*XLEN-1:0]   load_acc_s;

  logic [2*XLEN-1:0]   step_acc_s;
  logic [XLEN:0]       shifted_s;
  logic [XLEN:0]       diff_s;
  logic [XLEN:0]       sum_s;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     calc_res_s;

  assign BUSY   = busy_r;
  assign DONE   = done_r;
  assign RESULT = result_r;

  // Operand decode at request time: signedness, magnitudes and the no-iteration divide cases
  always_comb begin
    a_signed_s    = FUNCT3[2] ? ~FUNCT3[0] : (FUNCT3[1:0] == 2'b01 || FUNCT3[1:0] == 2'b10);
    b_signed_s    = FUNCT3[2] ? ~FUNCT3[0] : (FUNCT3[1:0] == 2'b01);
    a_neg_s       = a_signed_s & OPERAND_A[XLEN-1];
    b_neg_s       = b_signed_s & OPERAND_B[XLEN-1];
    mag_a_s       = negate_if(OPERAND_A, a_neg_s);
    mag_b_s       = negate_if(OPERAND_B, b_neg_s);
    div_zero_s    = FUNCT3[2] && (OPERAND_B == ZERO);
    div_ovf_s     = FUNCT3[2] && !FUNCT3[0] && (OPERAND_A == MIN_NEG) && (OPERAND_B == ONES);
    special_s     = div_zero_s | div_ovf_s;
    if (div_zero_s) begin
      special_res_s = FUNCT3[1] ? OPERAND_A : ONES;
    end else if (div_ovf_s) begin
      special_res_s = FUNCT3[1] ? ZERO : OPERAND_A;
    end else begin
      special_res_s = ZERO;
    end
    // Divide keeps {remainder, quotient}; multiply keeps {partial high, multiplier}
    load_opnd_s   = FUNCT3[2] ? mag_b_s : mag_a_s;
    load_acc_s    = FUNCT3[2] ? {ZERO, mag_a_s} : {ZERO, mag_b_s};
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod_s;
  logic [XLEN-1:0]   fast_res_s;

  // Single-cycle magnitude multiply with sign fix-up
  always_comb begin
    fast_prod_s = {ZERO, mag_a_s} * {ZERO, mag_b_s};
    fast_prod_s = (a_neg_s ^ b_neg_s) ? -fast_prod_s : fast_prod_s;
    fast_res_s  = (FUNCT3[1:0] == 2'b00) ? fast_prod_s[XLEN-1:0] : fast_prod_s[2*XLEN-1:XLEN];
  end
`endif

  // STEPS_PER_CYCLE iterations of restoring divide or shift-add multiply
  always_comb begin
    step_acc_s = acc_r;
    shifted_s  = {(XLEN+1){1'b0}};
    diff_s     = {(XLEN+1){1'b0}};
    sum_s      = {(XLEN+1){1'b0}};
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      if (funct3_r[2]) begin
        shifted_s = {step_acc_s[2*XLEN-1:XLEN], step_acc_s[XLEN-1]};
        diff_s    = shifted_s - {1'b0, opnd_r};
        if (!diff_s[XLEN]) begin
          step_acc_s = {diff_s[XLEN-1:0], step_acc_s[XLEN-2:0], 1'b1};
        end else begin
          step_acc_s = {shifted_s[XLEN-1:0], step_acc_s[XLEN-2:0], 1'b0};
        end
      end else begin
        sum_s      = {1'b0, step_acc_s[2*XLEN-1:XLEN]} + (step_acc_s[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        step_acc_s = {sum_s, step_acc_s[XLEN-1:1]};
      end
    end
  end

  // Final sign correction and result selection from the last iteration
  always_comb begin
    prod_s = neg_q_r ? -step_acc_s : step_acc_s;
    if (funct3_r[2]) begin
      if (funct3_r[1]) begin
        calc_res_s = negate_if(step_acc_s[2*XLEN-1:XLEN], neg_rem_r);
      end else begin
        calc_res_s = negate_if(step_acc_s[XLEN-1:0], neg_q_r);
      end
    end else if (funct3_r[1:0] == 2'b00) begin
      calc_res_s = prod_s[XLEN-1:0];
    end else begin
      calc_res_s = prod_s[2*XLEN-1:XLEN];
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r   <= S_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= ZERO;
      funct3_r  <= 3'b000;
      opnd_r    <= ZERO;
      acc_r     <= {2*XLEN{1'b0}};
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      cnt_r     <= {CW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (START && !FLUSH) begin
            funct3_r  <= FUNCT3;
            opnd_r    <= load_opnd_s;
            acc_r     <= load_acc_s;
            neg_q_r   <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s;
            cnt_r     <= CNT_N;
            if (special_s) begin
              state_r  <= S_FINISH;
              done_r   <= 1'b1;
              result_r <= special_res_s;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!FUNCT3[2]) begin
              state_r  <= S_FINISH;
              done_r   <= 1'b1;
              result_r <= fast_res_s;
`endif
            end else begin
              state_r <= S_CALC;
              busy_r  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          if (FLUSH) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end else begin
            acc_r <= step_acc_s;
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              state_r  <= S_FINISH;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
              result_r <= calc_res_s;
            end
          end
        end
        S_FINISH: begin
          state_r <= S_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit (XLEN=32, one step per cycle)
// against a plain-arithmetic reference model; honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic [2:0]  FUNCT3 = 3'b000;
  logic [31:0] OPERAND_A = 32'd0;
  logic [31:0] OPERAND_B = 32'd0;
  logic        FLUSH = 1'b0;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] last_result = 32'd0;

  muldiv_unit #(.XLEN(32), .STEPS_PER_CYCLE(1)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .FUNCT3(FUNCT3),
    .OPERAND_A(OPERAND_A), .OPERAND_B(OPERAND_B), .FLUSH(FLUSH),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics straight from the ISA rules
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ae, be, p;
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (f)
      3'b000, 3'b001, 3'b010, 3'b011: begin
        ae = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'd0, a};
        be = (f == 3'b001) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ae * be;
        return (f == 3'b000) ? p[31:0] : p[63:32];
      end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  // One request; optional stray START at cycle poke_cyc while the op is running
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int poke_cyc, input string tag);
    logic [31:0] exp;
    int lat, cyc, busy_cnt;
    exp = ref_result(f, a, b);
    lat = ref_latency(f, a, b);
    @(negedge CLK);
    START = 1'b1; FUNCT3 = f; OPERAND_A = a; OPERAND_B = b;
    @(negedge CLK);
    START = 1'b0;
    OPERAND_A = $urandom;
    OPERAND_B = $urandom;
    FUNCT3 = 3'($urandom_range(7, 0));
    cyc = 1;
    busy_cnt = 0;
    while (!DONE && cyc < 100) begin
      if (BUSY) busy_cnt++;
      @(negedge CLK);
      cyc++;
      START = (cyc == poke_cyc);
    end
    START = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(lat - 1));
    check({tag, "_busy_at_done"}, 64'(BUSY), 64'd0);
    check({tag, "_result"}, 64'(RESULT), 64'(exp));
    last_result = exp;
    @(negedge CLK);
    check({tag, "_done_pulse"}, 64'(DONE), 64'd0);
    check({tag, "_result_held"}, 64'(RESULT), 64'(exp));
  endtask

  initial begin
    int cyc, dones;
    logic [2:0] rf;
    logic [31:0] ra, rb;

    repeat (2) @(negedge CLK);
    check("reset_busy", 64'(BUSY), 64'd0);
    check("reset_done", 64'(DONE), 64'd0);
    check("reset_result", 64'(RESULT), 64'd0);
    RESET_N = 1'b1;

    run_op(3'b100, 32'd20, 32'hFFFF_FFFD, 0, "div_20_m3");
    run_op(3'b110, 32'd20, 32'hFFFF_FFFD, 0, "rem_20_m3");
    run_op(3'b101, 32'h1234_5678, 32'd0, 0, "divu_by0");
    run_op(3'b111, 32'h1234_5678, 32'd0, 0, "remu_by0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 0, "mulh_min");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_m1");
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0, "mul_7_m3");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_max");
    run_op(3'b100, 32'd1000, 32'hFFFF_FFF9, 5, "div_start_poke");

    // Flush mid-divide: operation dropped, RESULT keeps the previous value
    @(negedge CLK);
    START = 1'b1; FUNCT3 = 3'b100; OPERAND_A = 32'd12345; OPERAND_B = 32'd17;
    @(negedge CLK);
    START = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(negedge CLK);
      cyc++;
    end
    check("flush_busy_before", 64'(BUSY), 64'd1);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    check("flush_busy_after", 64'(BUSY), 64'd0);
    dones = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    check("flush_no_done", 64'(dones), 64'd0);
    check("flush_result_kept", 64'(RESULT), 64'(last_result));

    // Reset in the middle of CALC clears everything at once
    @(negedge CLK);
    START = 1'b1; FUNCT3 = 3'b100; OPERAND_A = 32'd999; OPERAND_B = 32'd3;
    @(negedge CLK);
    START = 1'b0;
    repeat (9) @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check("midreset_busy", 64'(BUSY), 64'd0);
    check("midreset_done", 64'(DONE), 64'd0);
    check("midreset_result", 64'(RESULT), 64'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    run_op(3'b101, 32'd100, 32'd7, 0, "divu_after_reset");

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(7, 0));
      case ($urandom_range(5, 0))
        0: ra = 32'd0;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: ra = 32'($urandom_range(20, 0));
        default: ra = $urandom;
      endcase
      case ($urandom_range(5, 0))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'h8000_0000;
        3: rb = 32'($urandom_range(20, 0));
        default: rb = $urandom;
      endcase
      run_op(rf, ra, rb, ($urandom_range(1, 0) == 1) ? int'($urandom_range(33, 2)) : 0, "random");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
